// File: rtl/sonic_echo_model.sv
// sonic_echo_model: HC-SR04-style ultrasonic sensor responder.
// Accepts a trigger pulse, waits an emulated burst time, then returns an echo
// pulse whose width encodes the programmed obstacle distance.
module sonic_echo_model #(
   parameter int CLK_PER_US  = 100,
   parameter int MIN_TRIG_US = 10,
   parameter int BURST_US    = 200,
   parameter int US_PER_CM   = 58,
   parameter int MIN_CM      = 2,
   parameter int MAX_CM      = 400,
   parameter int TIMEOUT_US  = 38000,
   parameter int HOLDOFF_US  = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trig,
   input  logic [8:0] dist_cm,
   output logic       echo,
   output logic       busy,
   output logic       done,
   output logic       trig_err
);

   localparam logic [15:0] CPU16     = 16'(CLK_PER_US);
   localparam logic [15:0] TRIG_CYC  = 16'(MIN_TRIG_US * CLK_PER_US);
   localparam logic [15:0] BURST16   = 16'(BURST_US);
   localparam logic [15:0] HOLD16    = 16'(HOLDOFF_US);
   localparam logic [15:0] TOUT16    = 16'(TIMEOUT_US);
   localparam logic [15:0] MIN_CM16  = 16'(MIN_CM);
   localparam logic [15:0] MAX_CM16  = 16'(MAX_CM);
   localparam logic [15:0] US_CM16   = 16'(US_PER_CM);
   localparam logic [15:0] MIN_ECHO  = 16'(MIN_CM * US_PER_CM);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      TRIG  = 3'd1,
      BURST = 3'd2,
      ECHO  = 3'd3,
      HOLD  = 3'd4
   } state_t;

   state_t      state;
   logic        s1;
   logic        s2;
   logic        rise;
   logic        fall;
   logic [15:0] width_cnt;
   logic [15:0] us_cnt;
   logic [15:0] state_us;
   logic [8:0]  dist_reg;
   logic [15:0] echo_us;
   logic [15:0] dur_us;
   logic        us_tick;
   logic        phase_end;

   assign rise = s1 & ~s2;
   assign fall = ~s1 & s2;

   // Two-flop synchronizer for the asynchronous trigger input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= trig;
         s2 <= s1;
      end
   end

   // Echo width in microseconds from the latched distance, with clamping and no-object timeout.
   always_comb begin
      if ({7'd0, dist_reg} > MAX_CM16)
         echo_us = TOUT16;
      else if ({7'd0, dist_reg} < MIN_CM16)
         echo_us = MIN_ECHO;
      else
         echo_us = {7'd0, dist_reg} * US_CM16;
   end

   // Length of the current timed state and end-of-state detection from the us prescaler.
   always_comb begin
      case (state)
         BURST:   dur_us = BURST16;
         ECHO:    dur_us = echo_us;
         HOLD:    dur_us = HOLD16;
         default: dur_us = 16'd1;
      endcase
      us_tick   = (us_cnt == CPU16 - 16'd1);
      phase_end = us_tick && (state_us == dur_us - 16'd1);
   end

   // Measurement state machine with registered echo/busy/done/trig_err outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         width_cnt <= 16'd0;
         us_cnt    <= 16'd0;
         state_us  <= 16'd0;
         dist_reg  <= 9'd0;
         echo      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         trig_err  <= 1'b0;
      end else begin
         done     <= 1'b0;
         trig_err <= 1'b0;
         case (state)
            IDLE: begin
               us_cnt   <= 16'd0;
               state_us <= 16'd0;
               echo     <= 1'b0;
               busy     <= 1'b0;
               if (rise) begin
                  state     <= TRIG;
                  // The rise cycle itself already has s1 high, so it is the first counted cycle.
                  width_cnt <= 16'd1;
               end
            end
            TRIG: begin
               if (fall) begin
                  if (width_cnt >= TRIG_CYC) begin
                     dist_reg <= dist_cm;
                     busy     <= 1'b1;
                     state    <= BURST;
                  end else begin
                     trig_err <= 1'b1;
                     state    <= IDLE;
                  end
               end else if (s1 && (width_cnt < TRIG_CYC)) begin
                  width_cnt <= width_cnt + 16'd1;
               end
            end
            BURST, ECHO, HOLD: begin
               // A new trigger while a measurement runs is flagged and otherwise ignored.
               if (rise)
                  trig_err <= 1'b1;
               if (phase_end) begin
                  us_cnt   <= 16'd0;
                  state_us <= 16'd0;
                  case (state)
                     BURST: begin
                        state <= ECHO;
                        echo  <= 1'b1;
                     end
                     ECHO: begin
                        state <= HOLD;
                        echo  <= 1'b0;
                        done  <= 1'b1;
                     end
                     default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  endcase
               end else if (us_tick) begin
                  us_cnt   <= 16'd0;
                  state_us <= state_us + 16'd1;
               end else begin
                  us_cnt <= us_cnt + 16'd1;
               end
            end
            default: begin
               state <= IDLE;
               echo  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sonic_echo_model.sv
// tb_sonic_echo_model: scoreboard bench for the ultrasonic echo responder,
// run with a scaled-down time base so every measurement stays short.
module tb_sonic_echo_model;

   localparam int CPU     = 2;
   localparam int MINTRIG = 10;
   localparam int BURST   = 20;
   localparam int USCM    = 58;
   localparam int MINCM   = 2;
   localparam int MAXCM   = 400;
   localparam int TOUT    = 3000;
   localparam int HOLD    = 100;

   logic       clk;
   logic       rst;
   logic       trig;
   logic [8:0] dist_cm;
   logic       echo;
   logic       busy;
   logic       done;
   logic       trig_err;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   int last_width = 0;
   int fall_cyc = 0;
   int w        = 0;
   logic echo_q = 1'b0;
   int exp_q[$];

   sonic_echo_model #(
      .CLK_PER_US (CPU),
      .MIN_TRIG_US(MINTRIG),
      .BURST_US   (BURST),
      .US_PER_CM  (USCM),
      .MIN_CM     (MINCM),
      .MAX_CM     (MAXCM),
      .TIMEOUT_US (TOUT),
      .HOLDOFF_US (HOLD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .trig    (trig),
      .dist_cm (dist_cm),
      .echo    (echo),
      .busy    (busy),
      .done    (done),
      .trig_err(trig_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int echo_us_model(input int d);
      if (d > MAXCM) return TOUT;
      if (d < MINCM) return MINCM * USCM;
      return d * USCM;
   endfunction

   // Echo monitor: measures every echo pulse and compares it with the scoreboard.
   always begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
      if (trig_err) err_cnt++;
      if (rst) begin
         w = 0;
         echo_q = 1'b0;
      end else begin
         if (echo) begin
            w++;
         end else if (echo_q) begin
            last_width = w;
            fall_cyc = cyc;
            check_value("done_at_fall", {31'd0, done}, 32'd1);
            if (exp_q.size() == 0) begin
               check_value("echo_unexpected", w, 0);
            end else begin
               int e;
               e = exp_q.pop_front();
               check_value("echo_width", w, e);
               $display("echo pulse: width %0d cycles, expected %0d", w, e);
            end
            w = 0;
         end
         echo_q = echo;
      end
   end

   task automatic pulse(input int hi_cyc);
      trig = 1'b1;
      repeat (hi_cyc) @(negedge clk);
      trig = 1'b0;
   endtask

   task automatic wait_level(input string tag, input bit use_busy, input logic level,
                             input int limit, output int n);
      bit ok;
      ok = 1'b0;
      n  = 0;
      while (n < limit && !ok) begin
         @(posedge clk);
         #1;
         if ((use_busy ? busy : echo) === level) ok = 1'b1;
         else n++;
      end
      check_value(tag, {31'd0, ok}, 32'd1);
   endtask

   task automatic measure(input int d, input int hi_cyc, input string tag);
      int n;
      int d0;
      int e0;
      d0 = done_cnt;
      e0 = err_cnt;
      @(negedge clk);
      dist_cm = d[8:0];
      exp_q.push_back(echo_us_model(d) * CPU);
      pulse(hi_cyc);
      wait_level({tag, "_rise"}, 1'b0, 1'b1, BURST * CPU + 50, n);
      check_value({tag, "_lat"}, n, BURST * CPU + 1);
      check_value({tag, "_busy"}, {31'd0, busy}, 32'd1);
      wait_level({tag, "_idle"}, 1'b1, 1'b0, 30000, n);
      check_value({tag, "_hold"}, cyc - fall_cyc, HOLD * CPU);
      check_value({tag, "_done"}, done_cnt - d0, 1);
      check_value({tag, "_err"}, err_cnt - e0, 0);
      $display("measure %s: dist %0d cm, trig %0d cycles, echo %0d cycles", tag, d, hi_cyc, last_width);
   endtask

   initial begin
      int n;
      int e0;
      bit busy_seen;
      bit stop;
      rst = 1'b1;
      trig = 1'b0;
      dist_cm = 9'd0;
      repeat (3) @(posedge clk);
      #1;
      check_value("rst_echo", {31'd0, echo}, 32'd0);
      check_value("rst_busy", {31'd0, busy}, 32'd0);
      check_value("rst_done", {31'd0, done}, 32'd0);
      check_value("rst_err", {31'd0, trig_err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Nominal 10 us trigger, 100 cm.
      measure(100, MINTRIG * CPU, "d100");

      // One cycle short of the minimum width is rejected.
      e0 = err_cnt;
      busy_seen = 1'b0;
      @(negedge clk);
      dist_cm = 9'd100;
      pulse(MINTRIG * CPU - 1);
      repeat (100) begin
         @(posedge clk);
         #1;
         busy_seen = busy_seen | busy | echo;
      end
      check_value("short_err", err_cnt - e0, 1);
      check_value("short_busy", {31'd0, busy_seen}, 32'd0);
      $display("short trigger: %0d cycles, trig_err pulses %0d", MINTRIG * CPU - 1, err_cnt - e0);

      // Exactly the minimum width is accepted.
      measure(7, MINTRIG * CPU, "d7");

      // Clamping and no-object boundaries.
      measure(500, MINTRIG * CPU, "d500");
      measure(401, MINTRIG * CPU, "d401");
      measure(0, MINTRIG * CPU, "d0");
      measure(1, MINTRIG * CPU, "d1");
      measure(2, MINTRIG * CPU, "d2");

      // Retrigger and distance change during ECHO must not disturb the echo.
      e0 = err_cnt;
      @(negedge clk);
      dist_cm = 9'd100;
      exp_q.push_back(echo_us_model(100) * CPU);
      pulse(MINTRIG * CPU);
      wait_level("mid_rise", 1'b0, 1'b1, BURST * CPU + 50, n);
      repeat (100) @(negedge clk);
      dist_cm = 9'd30;
      pulse(20 * CPU);
      wait_level("mid_idle", 1'b1, 1'b0, 30000, n);
      check_value("mid_err", err_cnt - e0, 1);
      $display("retrigger during echo: echo %0d cycles, trig_err pulses %0d", last_width, err_cnt - e0);

      // Asynchronous reset in the middle of an echo.
      @(negedge clk);
      dist_cm = 9'd100;
      exp_q.push_back(echo_us_model(100) * CPU);
      pulse(MINTRIG * CPU);
      wait_level("rst_rise", 1'b0, 1'b1, BURST * CPU + 50, n);
      repeat (50) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_value("rst_mid_echo", {31'd0, echo}, 32'd0);
      check_value("rst_mid_busy", {31'd0, busy}, 32'd0);
      exp_q.delete();
      $display("reset asserted mid-echo: echo %0d busy %0d", echo, busy);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      measure(50, MINTRIG * CPU, "d50");

      // Loop-back with a simple ranging controller model: stop below 40 cm.
      measure(30, MINTRIG * CPU, "loop30");
      stop = (last_width / (USCM * CPU)) < 40;
      check_value("loop30_stop", {31'd0, stop}, 32'd1);
      measure(60, MINTRIG * CPU, "loop60");
      stop = (last_width / (USCM * CPU)) < 40;
      check_value("loop60_stop", {31'd0, stop}, 32'd0);

      check_value("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
